glip_jtag_discovery_engine: RTL

Parametrised JTAG configuration-discovery engine for the GLIP JTAG backend, sitting between the JTAG TAP data register path and the transfer logic. It classifies each shift cycle as discovery or data transfer by comparing the first shifted-in word against a magic pattern. On a match, it shifts out a self-describing descriptor: word count, N configuration words, and an optional checksum. While the count word is shifted out, it captures a full inbound side-channel control word.

---
 rtl/glip_jtag_discovery_engine.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/glip_jtag_discovery_engine.sv
// ============================================================================
// Module   : glip_jtag_discovery_engine
// Purpose  : JTAG configuration-discovery engine for the GLIP JTAG backend.
//            The first word shifted in after Update-DR selects the cycle
//            type. If it equals MAGIC, the engine shifts out a descriptor:
//            count word, NUM_CONFIG_WORDS config words and an optional
//            checksum. Any other word marks the cycle as a data transfer.
//            While the count word goes out, the inbound bits are collected
//            as a side-channel control word.
// Revision : 1.0 - initial release
//
// Build option:
//   GLIP_JTAG_DISCOVERY_CHECKSUM_EN - when defined, a checksum word (XOR of
//   the count word and all config words) follows the last config word.
//
// Ports:
//   clk_i                   TCK-domain clock
//   rst_ni                  asynchronous reset, active low
//   config_discovery_tdi_i  serial data from the TAP, LSB first
//   shift_i                 TAP in Shift-DR; every bit advance needs it
//   update_i                TAP Update-DR; synchronous restart to IDLE
//   config_words_i          descriptor payload, word i at [i*W +: W]; static
//   config_discovery_tdo_o  serial descriptor output (combinational)
//   config_discovery_o      discovery cycle in progress
//   data_transfer_o         current cycle is a data transfer
//   ctrl_word_o             last captured side-channel word
//   ctrl_valid_o            one-cycle pulse when ctrl_word_o was updated
//   ctrl_logic_rst_o        one-cycle pulse when captured bit 0 was set
// ============================================================================
`default_nettype none

module glip_jtag_discovery_engine #(
  parameter int unsigned           WORD_WIDTH       = 16,
  parameter int unsigned           NUM_CONFIG_WORDS = 2,
  parameter logic [WORD_WIDTH-1:0] MAGIC            = {WORD_WIDTH{1'b1}}
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   config_discovery_tdi_i,
  input  logic                                   shift_i,
  input  logic                                   update_i,
  input  logic [NUM_CONFIG_WORDS*WORD_WIDTH-1:0] config_words_i,
  output logic                                   config_discovery_tdo_o,
  output logic                                   config_discovery_o,
  output logic                                   data_transfer_o,
  output logic [WORD_WIDTH-1:0]                  ctrl_word_o,
  output logic                                   ctrl_valid_o,
  output logic                                   ctrl_logic_rst_o
);

  localparam int unsigned c_bit_w = $clog2(WORD_WIDTH);
  localparam int unsigned c_idx_w = $clog2(NUM_CONFIG_WORDS + 1);

  localparam logic [c_bit_w-1:0]    c_bit_last   = c_bit_w'(WORD_WIDTH - 1);
  localparam logic [c_idx_w-1:0]    c_idx_last   = c_idx_w'(NUM_CONFIG_WORDS - 1);
  localparam logic [WORD_WIDTH-1:0] c_count_word = WORD_WIDTH'(NUM_CONFIG_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE            = 3'd0,
    ST_SEND_COUNT      = 3'd1,
    ST_SEND_WORDS      = 3'd2,
`ifdef GLIP_JTAG_DISCOVERY_CHECKSUM_EN
    ST_SEND_CHECKSUM   = 3'd3,
`endif
    ST_WAIT_FOR_UPDATE = 3'd4
  } state_e;

  state_e                  state_q,      state_d;
  logic [c_bit_w-1:0]      bit_cnt_q,    bit_cnt_d;
  logic [c_idx_w-1:0]      word_idx_q,   word_idx_d;
  logic [WORD_WIDTH-1:0]   in_reg_q,     in_reg_d;
  logic                    disc_q,       disc_d;
  logic                    xfer_q,       xfer_d;
  logic [WORD_WIDTH-1:0]   ctrl_word_q,  ctrl_word_d;
  logic                    ctrl_valid_q, ctrl_valid_d;
  logic                    ctrl_lrst_q,  ctrl_lrst_d;

  logic                    w_bit_last;
  logic [WORD_WIDTH-1:0]   w_full_word;
  logic [WORD_WIDTH-1:0]   w_cfg_word;
  logic                    w_tdo;

  assign w_bit_last = (bit_cnt_q == c_bit_last);

  // in_reg holds the bits already shifted in this word; the word completes
  // with the bit on tdi right now. in_reg first collects the magic word in
  // IDLE and is then reused to collect the side-channel word in SEND_COUNT.
  assign w_full_word = {config_discovery_tdi_i, in_reg_q[WORD_WIDTH-2:0]};

  // Select the config word addressed by word_idx.
  always_comb begin
    w_cfg_word = '0;
    for (int i = 0; i < int'(NUM_CONFIG_WORDS); i++) begin
      if (int'(word_idx_q) == i) begin
        w_cfg_word = config_words_i[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

`ifdef GLIP_JTAG_DISCOVERY_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] w_checksum;

  always_comb begin
    w_checksum = c_count_word;
    for (int i = 0; i < int'(NUM_CONFIG_WORDS); i++) begin
      w_checksum = w_checksum ^ config_words_i[i*WORD_WIDTH +: WORD_WIDTH];
    end
  end
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      word_idx_q   <= '0;
      in_reg_q     <= '0;
      disc_q       <= 1'b0;
      xfer_q       <= 1'b0;
      ctrl_word_q  <= '0;
      ctrl_valid_q <= 1'b0;
      ctrl_lrst_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      word_idx_q   <= word_idx_d;
      in_reg_q     <= in_reg_d;
      disc_q       <= disc_d;
      xfer_q       <= xfer_d;
      ctrl_word_q  <= ctrl_word_d;
      ctrl_valid_q <= ctrl_valid_d;
      ctrl_lrst_q  <= ctrl_lrst_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    word_idx_d   = word_idx_q;
    in_reg_d     = in_reg_q;
    disc_d       = disc_q;
    xfer_d       = xfer_q;
    ctrl_word_d  = ctrl_word_q;
    ctrl_valid_d = 1'b0;
    ctrl_lrst_d  = 1'b0;
    w_tdo        = 1'b0;

    // tdo follows the current state/bit position, independent of shift.
    unique case (state_q)
      ST_SEND_COUNT:    w_tdo = c_count_word[bit_cnt_q];
      ST_SEND_WORDS:    w_tdo = w_cfg_word[bit_cnt_q];
`ifdef GLIP_JTAG_DISCOVERY_CHECKSUM_EN
      ST_SEND_CHECKSUM: w_tdo = w_checksum[bit_cnt_q];
`endif
      default:          w_tdo = 1'b0;
    endcase

    if (update_i) begin
      // Restart wins over a simultaneous shift; ctrl_word is kept.
      state_d    = ST_IDLE;
      bit_cnt_d  = '0;
      word_idx_d = '0;
      in_reg_d   = '0;
      disc_d     = 1'b0;
      xfer_d     = 1'b0;
    end else if (shift_i) begin
      if (state_q != ST_WAIT_FOR_UPDATE) begin
        bit_cnt_d = w_bit_last ? '0 : bit_cnt_q + 1'b1;
      end

      unique case (state_q)
        ST_IDLE: begin
          in_reg_d[bit_cnt_q] = config_discovery_tdi_i;
          if (w_bit_last) begin
            if (w_full_word == MAGIC) begin
              state_d = ST_SEND_COUNT;
              disc_d  = 1'b1;
              xfer_d  = 1'b0;
            end else begin
              state_d = ST_WAIT_FOR_UPDATE;
              disc_d  = 1'b0;
              xfer_d  = 1'b1;
            end
          end
        end

        ST_SEND_COUNT: begin
          in_reg_d[bit_cnt_q] = config_discovery_tdi_i;
          if (w_bit_last) begin
            ctrl_word_d  = w_full_word;
            ctrl_valid_d = 1'b1;
            ctrl_lrst_d  = w_full_word[0];
            state_d      = ST_SEND_WORDS;
          end
        end

        ST_SEND_WORDS: begin
          if (w_bit_last) begin
            if (word_idx_q == c_idx_last) begin
              word_idx_d = '0;
`ifdef GLIP_JTAG_DISCOVERY_CHECKSUM_EN
              state_d    = ST_SEND_CHECKSUM;
`else
              state_d    = ST_WAIT_FOR_UPDATE;
`endif
            end else begin
              word_idx_d = word_idx_q + 1'b1;
            end
          end
        end

`ifdef GLIP_JTAG_DISCOVERY_CHECKSUM_EN
        ST_SEND_CHECKSUM: begin
          if (w_bit_last) begin
            state_d = ST_WAIT_FOR_UPDATE;
          end
        end
`endif

        default: begin
          // WAIT_FOR_UPDATE: surplus shift bits are ignored.
        end
      endcase
    end
  end

  assign config_discovery_tdo_o = w_tdo;
  assign config_discovery_o     = disc_q;
  assign data_transfer_o        = xfer_q;
  assign ctrl_word_o            = ctrl_word_q;
  assign ctrl_valid_o           = ctrl_valid_q;
  assign ctrl_logic_rst_o       = ctrl_lrst_q;

endmodule

`default_nettype wire
